// File: rtl/ds_tile_write_arbiter.sv
// rtl/ds_tile_write_arbiter.sv - round-robin arbiter mapping tile pixels to pixel-buffer writes
// Optional build macro: DS_COLOR_MAP_EN (z mapped to RGB332 terrain colour instead of raw z).
module ds_tile_write_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter int          TILE_DIM      = 9,
    parameter int          TILES_PER_ROW = 2,
    parameter int          SCREEN_W      = 640,
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter int          ACK_HOLDOFF   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [10*NUM_REQ-1:0] req_x,
    input  logic [10*NUM_REQ-1:0] req_y,
    input  logic [8*NUM_REQ-1:0]  req_z,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [31:0]           bus_address,
    output logic [7:0]            bus_writedata,
    output logic                  bus_write,
    input  logic                  bus_waitrequest,
    output logic                  busy,
    output logic [19:0]           pixel_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_ADDR,
        ST_WRITE,
        ST_ACK
    } state_t;

    localparam logic [9:0]  TILE_DIM_C = 10'(TILE_DIM);
    localparam logic [31:0] DIM_W      = 32'(TILE_DIM);
    localparam logic [31:0] TPR_W      = 32'(TILES_PER_ROW);
    localparam logic [31:0] PITCH_W    = 32'(SCREEN_W);
    localparam logic [7:0]  HOLDOFF_C  = 8'(ACK_HOLDOFF);

    state_t             state;
    state_t             state_next;
    logic [3:0]         rr_ptr;
    logic [3:0]         grant_idx;
    logic [3:0]         pick_idx;
    logic               pick_found;
    logic [NUM_REQ-1:0] eligible;
    logic [7:0]         holdoff [NUM_REQ];
    logic [9:0]         lat_x;
    logic [9:0]         lat_y;
    logic [7:0]         lat_z;
    logic               coord_ok;
    logic [31:0]        tile_col;
    logic [31:0]        tile_row;
    logic [31:0]        pix_x;
    logic [31:0]        pix_y;
    logic [31:0]        pix_addr;
    logic [7:0]         pix_data;
    int                 scan_idx;

    always_comb begin
        for (int g = 0; g < NUM_REQ; g++) begin
            eligible[g] = req_valid[g] && (holdoff[g] == 8'd0);
        end
    end

    // Search starts one past the last winner so a tile cannot win twice while another waits.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        scan_idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!pick_found && eligible[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = 4'(scan_idx);
            end
        end
    end

    always_comb begin
        coord_ok = (lat_x < TILE_DIM_C) && (lat_y < TILE_DIM_C);
        tile_col = 32'(grant_idx) % TPR_W;
        tile_row = 32'(grant_idx) / TPR_W;
        pix_x    = tile_col * DIM_W + {22'd0, lat_x};
        pix_y    = tile_row * DIM_W + {22'd0, lat_y};
        pix_addr = BASE_ADDR + pix_y * PITCH_W + pix_x;
    end

`ifdef DS_COLOR_MAP_EN
    always_comb begin
        if (lat_z < 8'd64) begin
            pix_data = 8'h03;
        end else if (lat_z < 8'd128) begin
            pix_data = 8'h1C;
        end else if (lat_z < 8'd192) begin
            pix_data = 8'h8C;
        end else begin
            pix_data = 8'hFF;
        end
    end
`else
    always_comb begin
        pix_data = lat_z;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus_write  = 1'b0;
        busy       = 1'b1;
        req_ack    = '0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (|eligible) begin
                    state_next = ST_ARB;
                end
            end
            ST_ARB: begin
                state_next = pick_found ? ST_ADDR : ST_IDLE;
            end
            ST_ADDR: begin
                state_next = coord_ok ? ST_WRITE : ST_ACK;
            end
            ST_WRITE: begin
                bus_write = 1'b1;
                if (!bus_waitrequest) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                for (int g = 0; g < NUM_REQ; g++) begin
                    req_ack[g] = (grant_idx == 4'(g));
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr        <= 4'(NUM_REQ - 1);
            grant_idx     <= 4'd0;
            lat_x         <= 10'd0;
            lat_y         <= 10'd0;
            lat_z         <= 8'd0;
            bus_address   <= 32'd0;
            bus_writedata <= 8'd0;
            pixel_count   <= 20'd0;
        end else begin
            if (state == ST_ARB && pick_found) begin
                grant_idx <= pick_idx;
                rr_ptr    <= pick_idx;
                lat_x     <= req_x[10*pick_idx +: 10];
                lat_y     <= req_y[10*pick_idx +: 10];
                lat_z     <= req_z[8*pick_idx +: 8];
            end
            // Out-of-range pixels leave the bus registers untouched; they are never written.
            if (state == ST_ADDR && coord_ok) begin
                bus_address   <= pix_addr;
                bus_writedata <= pix_data;
            end
            if (state == ST_WRITE && !bus_waitrequest) begin
                pixel_count <= pixel_count + 20'd1;
            end
        end
    end

    // Holdoff covers the tile's own output-update latency after it sees its ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < NUM_REQ; g++) begin
                holdoff[g] <= 8'd0;
            end
        end else begin
            for (int g = 0; g < NUM_REQ; g++) begin
                if (state == ST_ACK && grant_idx == 4'(g)) begin
                    holdoff[g] <= HOLDOFF_C;
                end else if (holdoff[g] != 8'd0) begin
                    holdoff[g] <= holdoff[g] - 8'd1;
                end
            end
        end
    end

endmodule
